mem_responder: RTL

- Memory-side responder for the CPU datapath's MAR/MDR interface.
- Serves the Read and Write strobes issued by the control unit.
- Inserts a programmable number of wait states, then signals completion on MFC (memory function complete) so the control unit can stall on slow memory.
- Contains the word-addressed storage array and replaces the single-cycle RAM instance behind MAR/MDR.

---
 rtl/mem_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Wait-state memory responder behind MAR/MDR: a word array with a Read/Write
// strobe handshake that raises MFC once the access has completed.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MAR_in,
  input  logic [DATA_W-1:0] MDR_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MFC,
  output logic              Busy,
  output logic              Err
);

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_wr;
  logic                  r_oor;
  logic [DATA_W-1:0]     r_mem [2**ADDR_BITS];

  logic w_req, w_oor;
  assign w_req = Read ^ Write;
  assign w_oor = |MAR_in[31:ADDR_BITS];

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      MFC     <= 1'b0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
      Mdatain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Read && Write) begin
            // Strobe collision: no access, complete immediately with an error.
            r_state <= S_DONE;
            MFC     <= 1'b1;
            Busy    <= 1'b1;
            Err     <= 1'b1;
          end else if (w_req) begin
            r_addr  <= MAR_in[ADDR_BITS-1:0];
            r_data  <= MDR_in;
            r_wr    <= Write;
            r_oor   <= w_oor;
            Err     <= w_oor;
            r_cnt   <= CW'(WAIT_STATES);
            Busy    <= 1'b1;
            r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!r_wr) Mdatain <= r_oor ? '0 : r_mem[r_addr];
          MFC     <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Held strobes keep us here; a new request needs both low first.
          if (!Read && !Write) begin
            r_state <= S_IDLE;
            MFC     <= 1'b0;
            Busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; the clr term aborts a write caught mid-access.
  always_ff @(posedge clk) begin
    if (clr && r_state == S_ACCESS && r_wr && !r_oor)
      r_mem[r_addr] <= r_data;
  end

endmodule
